// File: rtl/card_shoe.sv
// card_shoe: finite multi-deck shoe that deals one random rank per deal request,
// without replacement. Request lines arrive asynchronously and are synchronised
// and edge-detected here; a Galois LFSR picks a starting rank and a linear probe
// skips exhausted ranks.
module card_shoe #(
  parameter int          DECKS       = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       fast_clock,
  input  logic       resetb,
  input  logic       deal_req,
  input  logic       shuffle_req,
  output logic [3:0] card,
  output logic       card_valid,
  output logic       busy,
  output logic       empty,
  output logic [8:0] remaining
);

  localparam int         NUM_RANKS   = 13;
  localparam logic [5:0] FULL_COUNT  = 6'(4 * DECKS);
  localparam logic [8:0] FULL_REMAIN = 9'(52 * DECKS);
  localparam logic [15:0] LFSR_MASK  = 16'hB400;

  typedef enum logic {IDLE, SEARCH} state_t;

  // Synchroniser chains plus history flops for the two request lines
  logic [SYNC_STAGES-1:0] deal_sync_reg;
  logic [SYNC_STAGES-1:0] shuffle_sync_reg;
  logic                   deal_hist_reg;
  logic                   shuffle_hist_reg;
  logic                   deal_edge;
  logic                   shuffle_edge;

  // Selection LFSR
  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;

  // Dealer state
  state_t     state_reg, state_next;
  logic [3:0] ptr_reg, ptr_next;
  logic [8:0] remaining_reg, remaining_next;
  logic [3:0] card_reg, card_next;
  logic       card_valid_reg, card_valid_next;

  // Per-rank copy counts, gathered into one packed vector for reading
  logic [NUM_RANKS-1:0][5:0] count_all;
  logic [5:0]                cur_count;
  logic                      search_hit;
  logic [3:0]                lfsr_low;

  // Shift request lines through the synchroniser and keep one cycle of history
  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) begin
      deal_sync_reg    <= '0;
      shuffle_sync_reg <= '0;
      deal_hist_reg    <= 1'b0;
      shuffle_hist_reg <= 1'b0;
    end else begin
      deal_sync_reg    <= {deal_sync_reg[SYNC_STAGES-2:0], deal_req};
      shuffle_sync_reg <= {shuffle_sync_reg[SYNC_STAGES-2:0], shuffle_req};
      deal_hist_reg    <= deal_sync_reg[SYNC_STAGES-1];
      shuffle_hist_reg <= shuffle_sync_reg[SYNC_STAGES-1];
    end
  end

  assign deal_edge    = deal_sync_reg[SYNC_STAGES-1] & ~deal_hist_reg;
  assign shuffle_edge = shuffle_sync_reg[SYNC_STAGES-1] & ~shuffle_hist_reg;

  // Galois LFSR step; a nonzero seed can never collapse to zero
  always_comb begin
    lfsr_next = {1'b0, lfsr_reg[15:1]};
    if (lfsr_reg[0]) begin
      lfsr_next = lfsr_next ^ LFSR_MASK;
    end
  end

  // Free-running LFSR register
  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign lfsr_low = lfsr_reg[3:0];

  // Read the count of the rank under the probe pointer
  always_comb begin
    cur_count = '0;
    for (int i = 0; i < NUM_RANKS; i++) begin
      if (ptr_reg == 4'(i)) begin
        cur_count = count_all[i];
      end
    end
  end

  // A shuffle in the same cycle pre-empts any hit
  assign search_hit = (state_reg == SEARCH) && (cur_count != 6'd0) && !shuffle_edge;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
      logic [5:0] cnt_reg;

      // Per-rank counter: refilled on shuffle, decremented when this rank is dealt
      always_ff @(posedge fast_clock or negedge resetb) begin
        if (!resetb) begin
          cnt_reg <= FULL_COUNT;
        end else if (shuffle_edge) begin
          cnt_reg <= FULL_COUNT;
        end else if (search_hit && (ptr_reg == 4'(gi))) begin
          cnt_reg <= cnt_reg - 6'd1;
        end
      end

      assign count_all[gi] = cnt_reg;
    end
  endgenerate

  // Next-state and datapath updates for the deal FSM
  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    remaining_next  = remaining_reg;
    card_next       = card_reg;
    card_valid_next = 1'b0;
    if (shuffle_edge) begin
      state_next     = IDLE;
      remaining_next = FULL_REMAIN;
    end else begin
      case (state_reg)
        IDLE: begin
          if (deal_edge) begin
            if (remaining_reg == 9'd0) begin
              card_next       = 4'd0;
              card_valid_next = 1'b1;
            end else begin
              ptr_next   = (lfsr_low >= 4'd13) ? (lfsr_low - 4'd13) : lfsr_low;
              state_next = SEARCH;
            end
          end
        end
        SEARCH: begin
          if (search_hit) begin
            remaining_next  = remaining_reg - 9'd1;
            card_next       = ptr_reg + 4'd1;
            card_valid_next = 1'b1;
            state_next      = IDLE;
          end else begin
            ptr_next = (ptr_reg == 4'd12) ? 4'd0 : ptr_reg + 4'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Deal FSM state and output registers
  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) begin
      state_reg      <= IDLE;
      ptr_reg        <= 4'd0;
      remaining_reg  <= FULL_REMAIN;
      card_reg       <= 4'd0;
      card_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      remaining_reg  <= remaining_next;
      card_reg       <= card_next;
      card_valid_reg <= card_valid_next;
    end
  end

  assign card       = card_reg;
  assign card_valid = card_valid_reg;
  assign busy       = (state_reg == SEARCH);
  assign remaining  = remaining_reg;
  assign empty      = (remaining_reg == 9'd0);

endmodule
